// File: rtl/riscv_hazard_unit.sv
// Hazard unit for the 5-stage RISC-V pipeline: E-stage forwarding, multi-cycle load-use stall FSM, branch flush.
// Optional perf counters (stall_cycles, flush_events) are built when HAZARD_PERF_CNT_EN is defined.
module riscv_hazard_unit #(
   parameter int unsigned REG_ADDR_W     = 5,
   parameter int unsigned LOAD_USE_STALL = 1,
   parameter int unsigned CNT_W          = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [REG_ADDR_W-1:0] rs1_D,
   input  logic [REG_ADDR_W-1:0] rs2_D,
   input  logic [REG_ADDR_W-1:0] rs1_E,
   input  logic [REG_ADDR_W-1:0] rs2_E,
   input  logic [REG_ADDR_W-1:0] rd_E,
   input  logic                  MemRead_E,
   input  logic [REG_ADDR_W-1:0] rd_M,
   input  logic                  RegWrite_M,
   input  logic [REG_ADDR_W-1:0] rd_W,
   input  logic                  RegWrite_W,
   input  logic                  PCSrc_E,
   output logic [1:0]            ForwardA,
   output logic [1:0]            ForwardB,
   output logic                  Stall_F,
   output logic                  Stall_D,
   output logic                  Flush_D,
   output logic                  Flush_E
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]      stall_cycles,
   output logic [CNT_W-1:0]      flush_events
`endif
);

   if (LOAD_USE_STALL < 1 || LOAD_USE_STALL > 7 || CNT_W < 1) begin : g_param_check
      $error("riscv_hazard_unit: LOAD_USE_STALL must be 1..7 and CNT_W >= 1");
   end

   typedef enum logic {IDLE, HOLD} state_t;

   localparam logic [2:0] HOLD_CNT   = 3'(LOAD_USE_STALL - 1);
   localparam bit         MULTI_STALL = (LOAD_USE_STALL > 1);

   state_t     state, state_next;
   logic [2:0] cnt, cnt_next;
   logic       lu;
   logic       stall, flush_d, flush_e;
   logic [1:0] fwd_a, fwd_b;

   always_comb begin
      fwd_a = 2'b00;
      if (RegWrite_M && rd_M != '0 && rd_M == rs1_E)
         fwd_a = 2'b10;
      else if (RegWrite_W && rd_W != '0 && rd_W == rs1_E)
         fwd_a = 2'b01;
   end

   always_comb begin
      fwd_b = 2'b00;
      if (RegWrite_M && rd_M != '0 && rd_M == rs2_E)
         fwd_b = 2'b10;
      else if (RegWrite_W && rd_W != '0 && rd_W == rs2_E)
         fwd_b = 2'b01;
   end

   assign lu = MemRead_E && (rd_E != '0) && (rd_E == rs1_D || rd_E == rs2_D);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // A taken branch overrides both a fresh hazard and an in-flight HOLD sequence.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      stall      = 1'b0;
      flush_d    = 1'b0;
      flush_e    = 1'b0;
      if (PCSrc_E) begin
         flush_d    = 1'b1;
         flush_e    = 1'b1;
         state_next = IDLE;
         cnt_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (lu) begin
                  stall   = 1'b1;
                  flush_e = 1'b1;
                  if (MULTI_STALL) begin
                     state_next = HOLD;
                     cnt_next   = HOLD_CNT;
                  end
               end
            end
            HOLD: begin
               stall    = 1'b1;
               flush_e  = 1'b1;
               cnt_next = cnt - 3'd1;
               if (cnt == 3'd1)
                  state_next = IDLE;
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // Outputs are held low combinationally for the whole time reset is asserted.
   assign ForwardA = rst_n ? fwd_a : 2'b00;
   assign ForwardB = rst_n ? fwd_b : 2'b00;
   assign Stall_F  = rst_n & stall;
   assign Stall_D  = rst_n & stall;
   assign Flush_D  = rst_n & flush_d;
   assign Flush_E  = rst_n & flush_e;

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cycles <= '0;
         flush_events <= '0;
      end else begin
         if (Stall_D && stall_cycles != '1)
            stall_cycles <= stall_cycles + CNT_W'(1);
         if (PCSrc_E && flush_events != '1)
            flush_events <= flush_events + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_riscv_hazard_unit.sv
// Scoreboard bench for riscv_hazard_unit: two instances (1 and 3 bubble cycles) driven in parallel.
// With HAZARD_PERF_CNT_EN defined, the 3-bubble instance uses a 4-bit counter to exercise saturation.
module tb_riscv_hazard_unit;

   typedef struct {
      logic       rst_n;
      logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
      logic       mr, rwm, rww, pcsrc;
   } stim_t;

   typedef struct {
      int fa, fb;
      int st1, fd1, fe1;
      int st3, fd3, fe3;
      int sc, fl;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
   logic       MemRead_E, RegWrite_M, RegWrite_W, PCSrc_E;

   logic [1:0] fa1, fb1, fa3, fb3;
   logic       sf1, sd1, fd1, fe1, sf3, sd3, fd3, fe3;
`ifdef HAZARD_PERF_CNT_EN
   logic [3:0] sc3, fl3;
`endif

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;
   int   pend1 = 0;
   int   pend3 = 0;
   int   m_sc  = 0;
   int   m_fl  = 0;

   riscv_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(1)) u1 (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
      .rd_E(rd_E), .MemRead_E(MemRead_E), .rd_M(rd_M), .RegWrite_M(RegWrite_M),
      .rd_W(rd_W), .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
      .ForwardA(fa1), .ForwardB(fb1), .Stall_F(sf1), .Stall_D(sd1), .Flush_D(fd1), .Flush_E(fe1)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(), .flush_events()
`endif
   );

   riscv_hazard_unit #(.REG_ADDR_W(5), .LOAD_USE_STALL(3), .CNT_W(4)) u3 (
      .clk(clk), .rst_n(rst_n), .rs1_D(rs1_D), .rs2_D(rs2_D), .rs1_E(rs1_E), .rs2_E(rs2_E),
      .rd_E(rd_E), .MemRead_E(MemRead_E), .rd_M(rd_M), .RegWrite_M(RegWrite_M),
      .rd_W(rd_W), .RegWrite_W(RegWrite_W), .PCSrc_E(PCSrc_E),
      .ForwardA(fa3), .ForwardB(fb3), .Stall_F(sf3), .Stall_D(sd3), .Flush_D(fd3), .Flush_E(fe3)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cycles(sc3), .flush_events(fl3)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int fwd(input logic [4:0] rs, input stim_t s);
      if (s.rwm && s.rd_M != 0 && s.rd_M == rs) return 2;
      if (s.rww && s.rd_W != 0 && s.rd_W == rs) return 1;
      return 0;
   endfunction

   // pend = bubbles still owed after the current cycle for an accepted hazard.
   task automatic model(input stim_t s, input int lus, inout int pend,
                        output int st, output int fd, output int fe);
      bit lu;
      lu = s.mr && s.rd_E != 0 && (s.rd_E == s.rs1_D || s.rd_E == s.rs2_D);
      st = 0; fd = 0; fe = 0;
      if (!s.rst_n) begin
         pend = 0;
      end else if (s.pcsrc) begin
         fd = 1; fe = 1; pend = 0;
      end else if (pend > 0) begin
         st = 1; fe = 1; pend = pend - 1;
      end else if (lu) begin
         st = 1; fe = 1; pend = lus - 1;
      end
   endtask

   function automatic stim_t quiet();
      stim_t s;
      s.rst_n = 1'b1;
      s.rs1_D = 0; s.rs2_D = 0; s.rs1_E = 0; s.rs2_E = 0;
      s.rd_E = 0; s.rd_M = 0; s.rd_W = 0;
      s.mr = 0; s.rwm = 0; s.rww = 0; s.pcsrc = 0;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      exp_t e;
      @(posedge clk);
      #1;
      rst_n = s.rst_n; rs1_D = s.rs1_D; rs2_D = s.rs2_D; rs1_E = s.rs1_E; rs2_E = s.rs2_E;
      rd_E = s.rd_E; rd_M = s.rd_M; rd_W = s.rd_W; MemRead_E = s.mr;
      RegWrite_M = s.rwm; RegWrite_W = s.rww; PCSrc_E = s.pcsrc;
      e.fa = s.rst_n ? fwd(s.rs1_E, s) : 0;
      e.fb = s.rst_n ? fwd(s.rs2_E, s) : 0;
      model(s, 1, pend1, e.st1, e.fd1, e.fe1);
      model(s, 3, pend3, e.st3, e.fd3, e.fe3);
      if (!s.rst_n) begin
         m_sc = 0; m_fl = 0;
      end
      e.sc = m_sc;
      e.fl = m_fl;
      if (s.rst_n) begin
         if (e.st3 == 1 && m_sc < 15) m_sc++;
         if (s.pcsrc && m_fl < 15) m_fl++;
      end
      q.push_back(e);
   endtask

   task automatic chk(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("fwdA_1", int'(fa1), e.fa);
            chk("fwdB_1", int'(fb1), e.fb);
            chk("fwdA_3", int'(fa3), e.fa);
            chk("fwdB_3", int'(fb3), e.fb);
            chk("stallF_1", int'(sf1), e.st1);
            chk("stallD_1", int'(sd1), e.st1);
            chk("flushD_1", int'(fd1), e.fd1);
            chk("flushE_1", int'(fe1), e.fe1);
            chk("stallF_3", int'(sf3), e.st3);
            chk("stallD_3", int'(sd3), e.st3);
            chk("flushD_3", int'(fd3), e.fd3);
            chk("flushE_3", int'(fe3), e.fe3);
`ifdef HAZARD_PERF_CNT_EN
            chk("stall_cycles", int'(sc3), e.sc);
            chk("flush_events", int'(fl3), e.fl);
`endif
         end
      end
   end

   initial begin : driver
      stim_t s, h;
      rst_n = 1'b0; rs1_D = 0; rs2_D = 0; rs1_E = 0; rs2_E = 0; rd_E = 0; rd_M = 0; rd_W = 0;
      MemRead_E = 0; RegWrite_M = 0; RegWrite_W = 0; PCSrc_E = 0;

      // Reset with busy-looking inputs: every output must still be zero.
      s = quiet();
      s.rst_n = 0; s.mr = 1; s.rd_E = 7; s.rs1_D = 7; s.pcsrc = 1;
      s.rwm = 1; s.rd_M = 5; s.rs1_E = 5;
      drive(s);
      drive(s);

      // Forwarding priority.
      s = quiet();
      s.rd_M = 5; s.rd_W = 5; s.rwm = 1; s.rww = 1; s.rs1_E = 5; s.rs2_E = 5;
      drive(s);
      s.rwm = 0;
      drive(s);
      s.rd_M = 0; s.rd_W = 0; s.rwm = 1;
      drive(s);

      // Single load-use hazard, then a load to x0.
      h = quiet();
      h.mr = 1; h.rd_E = 7; h.rs2_D = 7;
      drive(h);
      repeat (4) drive(quiet());
      s = quiet();
      s.mr = 1; s.rd_E = 0; s.rs1_D = 0;
      drive(s);
      drive(quiet());

      // Back-to-back hazards with no dead cycle.
      drive(h);
      drive(quiet());
      drive(quiet());
      drive(h);
      repeat (4) drive(quiet());

      // Branch in the second stall cycle aborts the sequence.
      drive(h);
      s = quiet();
      s.pcsrc = 1;
      drive(s);
      repeat (2) drive(quiet());

      // Asynchronous reset while in HOLD.
      drive(h);
      s = quiet();
      s.rst_n = 0;
      drive(s);
      repeat (3) drive(quiet());

      // A long stall stream to push the narrow counter into saturation, then two branches.
      repeat (8) begin
         drive(h);
         drive(quiet());
         drive(quiet());
      end
      s = quiet();
      s.pcsrc = 1;
      drive(s);
      drive(quiet());
      drive(s);
      drive(quiet());

      // Randomized traffic with small register indices so matches are frequent.
      repeat (3000) begin
         s.rst_n = ($urandom_range(99) != 0);
         s.rs1_D = 5'($urandom_range(3));
         s.rs2_D = 5'($urandom_range(3));
         s.rs1_E = 5'($urandom_range(3));
         s.rs2_E = 5'($urandom_range(3));
         s.rd_E  = 5'($urandom_range(3));
         s.rd_M  = 5'($urandom_range(3));
         s.rd_W  = 5'($urandom_range(3));
         s.mr    = 1'($urandom_range(1));
         s.rwm   = 1'($urandom_range(1));
         s.rww   = 1'($urandom_range(1));
         s.pcsrc = ($urandom_range(9) == 0);
         drive(s);
      end

      repeat (3) @(negedge clk);
      #1;
      chk("scoreboard_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
